// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - requester and FIFO write-side bundle for fifo_write_arbiter
// Ports: req_valid/req_last/req_data in, req_ready out (per requester);
//        wfull in, winc/wdata out (FIFO write side); grant_id/busy out (status).
// master: arbiter side. slave: requesters + FIFO side.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int Data_Width = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*Data_Width-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wfull;
    logic                          winc;
    logic [Data_Width-1:0]         wdata;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    modport master (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata, grant_id, busy
    );

    modport slave (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata, grant_id, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin packet arbiter for the async FIFO write port
// Ports: wclk (write clock), wrst (sync active-high reset), bus (fifo_write_arbiter_if.master).
// Optional macro ARB_IDLE_TIMEOUT_EN: releases a grant whose owner stays idle for TIMEOUT cycles.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int Data_Width = 8,
    parameter int MAX_BURST  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                 wclk,
    input  logic                 wrst,
    fifo_write_arbiter_if.master bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    if (NUM_REQ < 2 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("fifo_write_arbiter: illegal parameter value");
    end

    typedef enum logic {IDLE, XFER} state_t;

    state_t                state, state_nxt;
    logic [ID_W-1:0]       grant_q;
    logic [ID_W-1:0]       last_gnt;
    logic [BC_W-1:0]       beat_cnt;
    logic [ID_W-1:0]       sel_id;
    logic                  sel_found;
    logic                  g_valid;
    logic                  g_last;
    logic [Data_Width-1:0] g_data;
    logic                  winc_c;
    logic                  rel_c;
    logic                  timeout_c;

    // Round-robin search starting one past the last owner, wrapping.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand      = '0;
        sel_id    = '0;
        sel_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last_gnt) + i) % NUM_REQ);
            if (!sel_found && bus.req_valid[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    // Constant-index mux of the granted requester's signals.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
                g_data  = bus.req_data[i*Data_Width +: Data_Width];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        winc_c        = 1'b0;
        rel_c         = 1'b0;
        bus.req_ready = '0;
        bus.wdata     = '0;
        case (state)
            IDLE: begin
                if (sel_found) state_nxt = XFER;
            end
            XFER: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == ID_W'(i)) bus.req_ready[i] = !bus.wfull;
                end
                winc_c    = g_valid & !bus.wfull;
                bus.wdata = g_data;
                // Packet end or burst cap; the cap forces re-arbitration mid-packet.
                if (winc_c && (g_last || beat_cnt == BC_W'(MAX_BURST - 1))) rel_c = 1'b1;
                if (timeout_c) rel_c = 1'b1;
                if (rel_c) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= IDLE;
            grant_q  <= '0;
            last_gnt <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_q  <= sel_id;
                        beat_cnt <= '0;
                    end
                end
                XFER: begin
                    if (winc_c) beat_cnt <= beat_cnt + 1'b1;
                    if (rel_c)  last_gnt <= grant_q;
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_IDLE_TIMEOUT_EN
    localparam int IC_W = $clog2(TIMEOUT + 1);
    logic [IC_W-1:0] idle_cnt;

    // Counts only cycles where the owner could send but does not.
    always_ff @(posedge wclk) begin
        if (wrst || state != XFER || winc_c || bus.wfull) begin
            idle_cnt <= '0;
        end else if (!g_valid) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout_c = (state == XFER) && !g_valid && !bus.wfull &&
                       (idle_cnt == IC_W'(TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
`endif

    assign bus.winc     = winc_c;
    assign bus.grant_id = grant_q;
    assign bus.busy     = (state == XFER);
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO among NUM_REQ requesters in the write-clock domain.
- Grants one requester at a time and holds the grant for a packet, ending on the last beat or on a burst cap.
- Drives winc/wdata straight into the FIFO write side and gates all transfers on wfull.

Parameters:
NUM_REQ, 4, number of requesters (>=2); ID_W = $clog2(NUM_REQ)
Data_Width, 8, FIFO data width
MAX_BURST, 4, max beats per grant before forced re-arbitration (>=1)
TIMEOUT, 16, idle-valid cycles before forced release (used only with ARB_IDLE_TIMEOUT_EN)

Ports:
wclk  in  1  write-domain clock
wrst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  per-requester last beat of packet
req_data  in  NUM_REQ*Data_Width  flattened data; requester i uses bits [i*Data_Width +: Data_Width]
req_ready  out  NUM_REQ  per-requester beat accepted this cycle when valid&ready
wfull  in  1  FIFO full flag (registered in FIFO)
winc  out  1  FIFO write enable
wdata  out  Data_Width  FIFO write data
grant_id  out  ID_W  currently or last granted requester
busy  out  1  high in XFER state

Behaviour:
- Reset (wrst high at posedge wclk): state=IDLE, grant_id=0, last_gnt=NUM_REQ-1 (requester 0 wins first), beat_cnt=0, busy=0. Combinational outputs are winc=0, req_ready=0, wdata=0 while in IDLE.
- States IDLE, XFER.
- IDLE behaviour:
  - If any req_valid is high, select the first valid requester searching from last_gnt+1 upward, wrapping modulo NUM_REQ.
  - Register the selection into grant_id, clear beat_cnt, and go to XFER.
  - No beat transfers in IDLE. Arbitration costs exactly 1 cycle.
- XFER outputs (combinational):
  - g = grant_id.
  - req_ready[g] = !wfull; all other req_ready bits = 0.
  - winc = req_valid[g] & !wfull.
  - wdata = req_data slice g.
- XFER counting and release:
  - Each winc increments beat_cnt.
  - Release when winc & (req_last[g] | beat_cnt==MAX_BURST-1): next state IDLE, last_gnt<=g.
  - Release with winc=0 is impossible, except via the timeout option.
- req_valid[g] low in XFER: grant is held (packet lock), no write, beat_cnt holds.
- wfull high: winc=0 and req_ready=0 for all requesters, beat_cnt holds, state holds. Transfer resumes on the first cycle wfull is low.
- Burst cap splits longer packets. The same requester re-enters arbitration and resumes with its next beat. Downstream tolerates interleaved packet fragments.
- A requester must keep data and last stable while valid&!ready (standard valid/ready rule). The arbiter never drops or duplicates a beat.
- Requesters that are not granted see req_ready=0 regardless of wfull.
- Reset mid-XFER: the next cycle is IDLE with reset values. Beats already written stay in the FIFO with no rollback.
- beat_cnt width is $clog2(MAX_BURST+1). There is no wrap within a grant.
- Throughput: at most one beat per cycle. Single-beat packets alternate IDLE/XFER, giving 50% utilisation.

Optional Feature:
ARB_IDLE_TIMEOUT_EN
- Defined:
  - An idle counter runs in XFER while req_valid[g]=0 and wfull=0. It clears on any winc or on any cycle with wfull=1.
  - When the counter reaches TIMEOUT-1, the grant is forced to IDLE on the next edge with last_gnt<=g.
  - Counter resets to 0 on wrst.
- Not defined: no counter logic exists, and the grant is held indefinitely until a last beat or the burst cap.

Test Plan:
1. Reset: wrst=1 for 2 cycles with all req_valid=4'b1111 -> winc=0, req_ready=0, busy=0, grant_id=0 throughout. Grant to 0 appears one cycle after wrst falls.
2. Only req 2 valid with 3-beat packet 0x21,0x22,0x23 (last on 0x23), wfull=0 -> one IDLE cycle, then grant_id=2 and winc=1 for 3 consecutive cycles carrying wdata 0x21,0x22,0x23, then busy=0.
3. All 4 requesters send continuous single-beat packets (data 0x10+i) -> write order 0x10,0x11,0x12,0x13,0x10, one write every 2 cycles.
4. Req 1 sends a 6-beat packet 0x40..0x45 while req 3 has a 1-beat 0x77 pending -> writes 0x40..0x43, then 0x77, then 0x44,0x45. grant_id sequence 1,3,1.
5. wfull forced high for 3 cycles after beat 2 of a 4-beat packet -> winc=0, req_ready=0 for those 3 cycles. Beats 3-4 then follow with no loss or duplication, and beat_cnt reaches 3 before release.
6. With ARB_IDLE_TIMEOUT_EN, req 0 drops valid mid-packet for 20 cycles -> release after 16 idle cycles and req 1 is granted. Without the macro, the grant stays on req 0 and req 1 is never granted.
